// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Registered arbiter with round-robin or fixed priority selection and a
//   configurable grant-hold policy. A two-state FSM (IDLE / BUSY) owns the
//   registered grant. Arbitration combines two priority encodes: one over the
//   requests inside the rotating mask and one over all requests. The masked
//   result wins whenever it is nonzero.
//
// Parameters
//   PORTS        number of requesters (2..64)
//   ROUND_ROBIN  1 = rotating priority, 0 = fixed priority (mask forced empty)
//   BLOCK        "NONE" | "REQUEST" | "ACKNOWLEDGE" : when a held grant releases
//   LSB_PRIORITY "LOW" = lower index wins, "HIGH" = higher index wins
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   request        one request bit per requester
//   acknowledge    per-requester release strobe (BLOCK="ACKNOWLEDGE" only)
//   grant          registered one-hot grant, or zero
//   grant_valid    registered, high exactly when grant is nonzero
//   grant_encoded  registered binary index of the granted port, 0 when idle
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int    PORTS        = 4,
  parameter int    ROUND_ROBIN  = 1,
  parameter string BLOCK        = "NONE",
  parameter string LSB_PRIORITY = "LOW"
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PORTS-1:0]         request,
  input  logic [PORTS-1:0]         acknowledge,
  output logic [PORTS-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(PORTS)-1:0] grant_encoded
);

  localparam int IDX_W   = $clog2(PORTS);
  localparam bit IS_HIGH = (LSB_PRIORITY == "HIGH");
  localparam bit USE_RR  = (ROUND_ROBIN != 0);
  localparam bit BLK_REQ = (BLOCK == "REQUEST");
  localparam bit BLK_ACK = (BLOCK == "ACKNOWLEDGE");

  // After reset the "last winner" sits at the lowest-priority extreme so the
  // first grant goes to the highest-priority index.
  localparam logic [IDX_W-1:0] LAST_RST = IS_HIGH ? '0 : IDX_W'(PORTS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [IDX_W-1:0] last_idx;

  logic [PORTS-1:0] mask;
  logic [PORTS-1:0] masked_req;
  logic [IDX_W-1:0] win_idx;
  logic [PORTS-1:0] win_onehot;
  logic             req_any;
  logic             release_now;

  // Priority encoder: index of the highest-priority set bit of v.
  function automatic logic [IDX_W-1:0] prio_pick(input logic [PORTS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    if (IS_HIGH) begin
      for (int i = 0; i < PORTS; i++) begin
        if (v[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = PORTS - 1; i >= 0; i--) begin
        if (v[i]) idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  // Mask keeps only the ports that come after the last winner in rotation
  // order; at the extreme index it is empty and the unmasked encode decides.
  always_comb begin
    mask = '0;
    if (USE_RR) begin
      for (int i = 0; i < PORTS; i++) begin
        if (IS_HIGH) mask[i] = (i < int'(last_idx));
        else         mask[i] = (i > int'(last_idx));
      end
    end
  end

  assign masked_req = request & mask;
  assign req_any    = |request;
  assign win_idx    = (|masked_req) ? prio_pick(masked_req) : prio_pick(request);
  assign win_onehot = {{(PORTS-1){1'b0}}, 1'b1} << win_idx;

  // Release test only ever looks at the currently granted port.
  always_comb begin
    release_now = 1'b1;
    if (BLK_REQ)      release_now = ~request[grant_encoded];
    else if (BLK_ACK) release_now = acknowledge[grant_encoded] | ~request[grant_encoded];
  end

  // ---- registered grant stage (request sampled -> grant one cycle later) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_idx      <= LAST_RST;
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            state         <= BUSY;
            last_idx      <= win_idx;
            grant         <= win_onehot;
            grant_valid   <= 1'b1;
            grant_encoded <= win_idx;
          end
        end
        BUSY: begin
          if (release_now) begin
            if (req_any) begin
              last_idx      <= win_idx;
              grant         <= win_onehot;
              grant_valid   <= 1'b1;
              grant_encoded <= win_idx;
            end else begin
              state         <= IDLE;
              grant         <= '0;
              grant_valid   <= 1'b0;
              grant_encoded <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter
//   Directed bench for rr_arbiter. Five instances cover the parameter
//   combinations of interest: round-robin/NONE, REQUEST hold, ACKNOWLEDGE
//   hold, fixed priority and HIGH lsb priority. All share clock and reset.
// -----------------------------------------------------------------------------
module tb_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic [3:0] req_rr = '0, req_q = '0, req_a = '0, req_f = '0, req_h = '0;
  logic [3:0] ack_a  = '0;
  logic [3:0] zero4  = '0;

  logic [3:0] g_rr, g_q, g_a, g_f, g_h;
  logic       v_rr, v_q, v_a, v_f, v_h;
  logic [1:0] e_rr, e_q, e_a, e_f, e_h;

  int tests = 0;
  int fails = 0;

  rr_arbiter #(.PORTS(4), .ROUND_ROBIN(1), .BLOCK("NONE"), .LSB_PRIORITY("LOW")) u_rr (
    .clk(clk), .rst_n(rst_n), .request(req_rr), .acknowledge(zero4),
    .grant(g_rr), .grant_valid(v_rr), .grant_encoded(e_rr));

  rr_arbiter #(.PORTS(4), .ROUND_ROBIN(1), .BLOCK("REQUEST"), .LSB_PRIORITY("LOW")) u_q (
    .clk(clk), .rst_n(rst_n), .request(req_q), .acknowledge(zero4),
    .grant(g_q), .grant_valid(v_q), .grant_encoded(e_q));

  rr_arbiter #(.PORTS(4), .ROUND_ROBIN(1), .BLOCK("ACKNOWLEDGE"), .LSB_PRIORITY("LOW")) u_a (
    .clk(clk), .rst_n(rst_n), .request(req_a), .acknowledge(ack_a),
    .grant(g_a), .grant_valid(v_a), .grant_encoded(e_a));

  rr_arbiter #(.PORTS(4), .ROUND_ROBIN(0), .BLOCK("NONE"), .LSB_PRIORITY("LOW")) u_f (
    .clk(clk), .rst_n(rst_n), .request(req_f), .acknowledge(zero4),
    .grant(g_f), .grant_valid(v_f), .grant_encoded(e_f));

  rr_arbiter #(.PORTS(4), .ROUND_ROBIN(1), .BLOCK("NONE"), .LSB_PRIORITY("HIGH")) u_h (
    .clk(clk), .rst_n(rst_n), .request(req_h), .acknowledge(zero4),
    .grant(g_h), .grant_valid(v_h), .grant_encoded(e_h));

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares grant, grant_encoded and grant_valid against the expectation;
  // expected valid is implied by a nonzero expected grant.
  task automatic chk(input string tag, input logic [3:0] g, input logic [1:0] e,
                     input logic v, input logic [3:0] eg, input logic [1:0] ee);
    logic ev;
    ev = |eg;
    tests++;
    assert (g === eg) else begin
      fails++;
      $error("FAIL %s grant: observed %b expected %b", tag, g, eg);
    end
    tests++;
    assert (e === ee) else begin
      fails++;
      $error("FAIL %s grant_encoded: observed %0d expected %0d", tag, e, ee);
    end
    tests++;
    assert (v === ev) else begin
      fails++;
      $error("FAIL %s grant_valid: observed %b expected %b", tag, v, ev);
    end
  endtask

  initial begin
    // Reset state, with requests already present while in reset.
    req_rr = 4'b1111;
    #2;
    chk("rst_async", g_rr, e_rr, v_rr, 4'b0000, 2'd0);
    tick();
    tick();
    chk("rst_held", g_rr, e_rr, v_rr, 4'b0000, 2'd0);
    chk("rst_hi", g_h, e_h, v_h, 4'b0000, 2'd0);
    rst_n = 1'b1;

    // Round-robin rotation over a full request vector.
    tick(); chk("rr_0", g_rr, e_rr, v_rr, 4'b0001, 2'd0);
    tick(); chk("rr_1", g_rr, e_rr, v_rr, 4'b0010, 2'd1);
    tick(); chk("rr_2", g_rr, e_rr, v_rr, 4'b0100, 2'd2);
    tick(); chk("rr_3", g_rr, e_rr, v_rr, 4'b1000, 2'd3);
    tick(); chk("rr_wrap", g_rr, e_rr, v_rr, 4'b0001, 2'd0);
    tick(); chk("rr_1b", g_rr, e_rr, v_rr, 4'b0010, 2'd1);
    tick(); chk("rr_2b", g_rr, e_rr, v_rr, 4'b0100, 2'd2);

    // Reset mid-grant drops the grant before the next edge.
    rst_n = 1'b0;
    #1;
    chk("rst_mid", g_rr, e_rr, v_rr, 4'b0000, 2'd0);
    req_rr = 4'b0110;
    tick(); chk("rst_mid_hold", g_rr, e_rr, v_rr, 4'b0000, 2'd0);
    rst_n = 1'b1;
    tick(); chk("rst_resume", g_rr, e_rr, v_rr, 4'b0010, 2'd1);

    // Requests removed: back to idle.
    req_rr = 4'b0000;
    tick(); chk("rr_idle", g_rr, e_rr, v_rr, 4'b0000, 2'd0);

    // Single persistent requester keeps winning without a gap.
    req_rr = 4'b0100;
    tick(); chk("solo_0", g_rr, e_rr, v_rr, 4'b0100, 2'd2);
    tick(); chk("solo_1", g_rr, e_rr, v_rr, 4'b0100, 2'd2);

    // Wrap: last grant at index 3, then 1001 goes to index 0.
    req_rr = 4'b1000;
    tick(); chk("wrap_pre", g_rr, e_rr, v_rr, 4'b1000, 2'd3);
    req_rr = 4'b1001;
    tick(); chk("wrap_lo", g_rr, e_rr, v_rr, 4'b0001, 2'd0);
    tick(); chk("wrap_next", g_rr, e_rr, v_rr, 4'b1000, 2'd3);
    req_rr = 4'b0000;

    // REQUEST hold: grant stays while request[0] is high.
    req_q = 4'b0101;
    tick(); chk("req_hold0", g_q, e_q, v_q, 4'b0001, 2'd0);
    tick(); chk("req_hold1", g_q, e_q, v_q, 4'b0001, 2'd0);
    tick(); chk("req_hold2", g_q, e_q, v_q, 4'b0001, 2'd0);
    req_q = 4'b0100;
    tick(); chk("req_move", g_q, e_q, v_q, 4'b0100, 2'd2);
    req_q = 4'b0000;
    tick(); chk("req_idle", g_q, e_q, v_q, 4'b0000, 2'd0);

    // ACKNOWLEDGE hold: ack on a non-granted port is ignored.
    req_a = 4'b1010;
    tick(); chk("ack_grant", g_a, e_a, v_a, 4'b0010, 2'd1);
    ack_a = 4'b1000;
    tick(); chk("ack_other", g_a, e_a, v_a, 4'b0010, 2'd1);
    ack_a = 4'b0000;
    tick(); chk("ack_none", g_a, e_a, v_a, 4'b0010, 2'd1);
    ack_a = 4'b0010;
    tick(); chk("ack_release", g_a, e_a, v_a, 4'b1000, 2'd3);
    ack_a = 4'b0000;
    tick(); chk("ack_held", g_a, e_a, v_a, 4'b1000, 2'd3);
    req_a = 4'b0000;

    // Fixed priority: lowest index always wins.
    req_f = 4'b1111;
    tick(); chk("fix_0", g_f, e_f, v_f, 4'b0001, 2'd0);
    tick(); chk("fix_1", g_f, e_f, v_f, 4'b0001, 2'd0);
    req_f = 4'b1100;
    tick(); chk("fix_2", g_f, e_f, v_f, 4'b0100, 2'd2);
    tick(); chk("fix_3", g_f, e_f, v_f, 4'b0100, 2'd2);
    req_f = 4'b0000;

    // HIGH lsb priority from reset: 0011 -> index 1 then index 0.
    req_h = 4'b0011;
    tick(); chk("hi_0", g_h, e_h, v_h, 4'b0010, 2'd1);
    tick(); chk("hi_1", g_h, e_h, v_h, 4'b0001, 2'd0);
    tick(); chk("hi_2", g_h, e_h, v_h, 4'b0010, 2'd1);
    req_h = 4'b0000;
    tick(); chk("hi_idle", g_h, e_h, v_h, 4'b0000, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
